instr_fetch_ctrl: RTL and testbench

- Control unit at the consuming end of the program-counter/instruction-memory path of the 16-bit processor.
- Drives the PC increment and clear inputs, and latches the 16-bit instruction word returned by instruction ROM into an internal IR.
- Decodes the IR through a fetch/decode/execute FSM and issues one-hot-per-function control strobes to data memory, register file and ALU.
- One instruction completes every 3 cycles (LOAD: 4 cycles); HALT parks the FSM until reset.

---
 rtl/instr_fetch_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// instr_fetch_ctrl
//   Fetch/decode/execute controller for the 16-bit processor. It drives the PC
//   clear and increment inputs, captures the ROM word into IR_q during FETCH,
//   and issues control strobes to data memory, the register file and the ALU.
//   Each instruction takes 3 cycles (FETCH, DECODE, execute). LOAD takes 4
//   cycles because it has two execute states. HALT parks the FSM until reset.
//
// Ports
//   Clk         in   system clock; all state changes on its rising edge
//   Clr         in   synchronous active-low reset
//   Instr       in   [15:0] ROM word at the current PC (1-cycle synchronous read)
//   PC_clr      out  active-low PC clear; 0 only in INIT
//   PC_up       out  PC increment enable; 1 only in FETCH
//   IR_q        out  [15:0] latched instruction register
//   D_addr      out  [D_ADDR_W-1:0] data-memory address (IR_q[7:0])
//   D_wr        out  data-memory write enable
//   RF_s        out  RF write-data select (1 = memory data, 0 = ALU result)
//   RF_W_addr   out  [RF_ADDR_W-1:0] RF write address
//   RF_W_en     out  RF write enable
//   RF_Ra_addr  out  [RF_ADDR_W-1:0] RF read port A address
//   RF_Rb_addr  out  [RF_ADDR_W-1:0] RF read port B address
//   ALU_s0      out  [2:0] ALU op: 000 pass A, 001 A+B, 010 A-B
//   State       out  [STATE_W-1:0] current state code (debug display)
//
// Handshake: there is none. ROM and memories are fixed-latency slaves. Instr
// is only sampled at the edge that ends FETCH, and every other output is a
// pure function of (state, IR_q).
// -----------------------------------------------------------------------------
module instr_fetch_ctrl #(
  parameter int D_ADDR_W  = 8,
  parameter int RF_ADDR_W = 4,
  parameter int STATE_W   = 4
) (
  input  logic                 Clk,
  input  logic                 Clr,
  input  logic [15:0]          Instr,
  output logic                 PC_clr,
  output logic                 PC_up,
  output logic [15:0]          IR_q,
  output logic [D_ADDR_W-1:0]  D_addr,
  output logic                 D_wr,
  output logic                 RF_s,
  output logic [RF_ADDR_W-1:0] RF_W_addr,
  output logic                 RF_W_en,
  output logic [RF_ADDR_W-1:0] RF_Ra_addr,
  output logic [RF_ADDR_W-1:0] RF_Rb_addr,
  output logic [2:0]           ALU_s0,
  output logic [STATE_W-1:0]   State
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [3:0] OP_NOOP  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_LOAD  = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_HALT  = 4'b0101;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

  state_t      state_q;
  state_t      state_d;
  logic [15:0] ir_q;
  logic [3:0]  opcode;

  assign opcode = ir_q[15:12];
  assign IR_q   = ir_q;
  assign State  = STATE_W'(state_q);

  // State register and IR. Reset wins over every transition, so a reset in
  // mid-instruction abandons the instruction before any later strobe.
  always_ff @(posedge Clk) begin
    if (!Clr) begin
      state_q <= S_INIT;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH) begin
        ir_q <= Instr;
      end
    end
  end

  // Next state and outputs, decoded from (state, IR_q) only.
  always_comb begin
    state_d    = state_q;
    PC_clr     = 1'b1;
    PC_up      = 1'b0;
    D_addr     = '0;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = '0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    ALU_s0     = ALU_PASS;

    case (state_q)
      S_INIT: begin
        // PC is held cleared for one cycle so ROM can present word 0.
        PC_clr  = 1'b0;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        PC_up   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_NOOP:  state_d = S_NOOP;
          OP_STORE: state_d = S_STORE;
          OP_LOAD:  state_d = S_LOAD_A;
          OP_ADD:   state_d = S_ADD;
          OP_SUB:   state_d = S_SUB;
          OP_HALT:  state_d = S_HALT;
          default:  state_d = S_NOOP;
        endcase
      end
      S_NOOP: begin
        state_d = S_FETCH;
      end
      S_STORE: begin
        D_addr     = ir_q[D_ADDR_W-1:0];
        RF_Ra_addr = RF_ADDR_W'(ir_q[11:8]);
        D_wr       = 1'b1;
        state_d    = S_FETCH;
      end
      S_LOAD_A: begin
        // Memory read is in flight; the address must already be valid here.
        D_addr  = ir_q[D_ADDR_W-1:0];
        state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        D_addr    = ir_q[D_ADDR_W-1:0];
        RF_s      = 1'b1;
        RF_W_addr = RF_ADDR_W'(ir_q[11:8]);
        RF_W_en   = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADD: begin
        RF_Ra_addr = RF_ADDR_W'(ir_q[11:8]);
        RF_Rb_addr = RF_ADDR_W'(ir_q[7:4]);
        RF_W_addr  = RF_ADDR_W'(ir_q[3:0]);
        RF_W_en    = 1'b1;
        ALU_s0     = ALU_ADD;
        state_d    = S_FETCH;
      end
      S_SUB: begin
        RF_Ra_addr = RF_ADDR_W'(ir_q[11:8]);
        RF_Rb_addr = RF_ADDR_W'(ir_q[7:4]);
        RF_W_addr  = RF_ADDR_W'(ir_q[3:0]);
        RF_W_en    = 1'b1;
        ALU_s0     = ALU_SUB;
        state_d    = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_ctrl
//   Directed bench for instr_fetch_ctrl. Each step advances one clock and
//   samples 1 time unit after the rising edge. Expected values are written by
//   hand from the instruction encodings.
// -----------------------------------------------------------------------------
module tb_instr_fetch_ctrl;

  logic        Clk;
  logic        Clr;
  logic [15:0] Instr;
  logic        PC_clr;
  logic        PC_up;
  logic [15:0] IR_q;
  logic [7:0]  D_addr;
  logic        D_wr;
  logic        RF_s;
  logic [3:0]  RF_W_addr;
  logic        RF_W_en;
  logic [3:0]  RF_Ra_addr;
  logic [3:0]  RF_Rb_addr;
  logic [2:0]  ALU_s0;
  logic [3:0]  State;

  int n_assert;
  int n_fail;
  int up_count;

  instr_fetch_ctrl #(
    .D_ADDR_W (8),
    .RF_ADDR_W(4),
    .STATE_W  (4)
  ) dut (
    .Clk       (Clk),
    .Clr       (Clr),
    .Instr     (Instr),
    .PC_clr    (PC_clr),
    .PC_up     (PC_up),
    .IR_q      (IR_q),
    .D_addr    (D_addr),
    .D_wr      (D_wr),
    .RF_s      (RF_s),
    .RF_W_addr (RF_W_addr),
    .RF_W_en   (RF_W_en),
    .RF_Ra_addr(RF_Ra_addr),
    .RF_Rb_addr(RF_Rb_addr),
    .ALU_s0    (ALU_s0),
    .State     (State)
  );

  // Clock
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full output vector check for one cycle.
  task automatic chk_out(input string tag, input logic [3:0] st, input logic pc_clr,
                         input logic pc_up, input logic d_wr, input logic rf_s,
                         input logic w_en, input logic [2:0] alu, input logic [7:0] da,
                         input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] wa);
    chk({tag, ".State"},      16'(State),      16'(st));
    chk({tag, ".PC_clr"},     16'(PC_clr),     16'(pc_clr));
    chk({tag, ".PC_up"},      16'(PC_up),      16'(pc_up));
    chk({tag, ".D_wr"},       16'(D_wr),       16'(d_wr));
    chk({tag, ".RF_s"},       16'(RF_s),       16'(rf_s));
    chk({tag, ".RF_W_en"},    16'(RF_W_en),    16'(w_en));
    chk({tag, ".ALU_s0"},     16'(ALU_s0),     16'(alu));
    chk({tag, ".D_addr"},     16'(D_addr),     16'(da));
    chk({tag, ".RF_Ra_addr"}, 16'(RF_Ra_addr), 16'(ra));
    chk({tag, ".RF_Rb_addr"}, 16'(RF_Rb_addr), 16'(rb));
    chk({tag, ".RF_W_addr"},  16'(RF_W_addr),  16'(wa));
  endtask

  task automatic chk_fetch(input string tag);
    chk_out(tag, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 4'h0, 4'h0, 4'h0);
  endtask

  task automatic chk_quiet(input string tag, input logic [3:0] st);
    chk_out(tag, st, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 4'h0, 4'h0, 4'h0);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    Clr      = 1'b0;
    Instr    = 16'h0000;

    // Reset held for two cycles
    step();
    step();
    chk_out("rst", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 4'h0, 4'h0, 4'h0);
    chk("rst.IR_q", IR_q, 16'h0000);

    // Release: INIT is visible for this cycle, then the NOOP loop starts
    Clr = 1'b1;
    chk_out("init", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 4'h0, 4'h0, 4'h0);
    step();
    chk_fetch("noop0.fetch");
    step();
    chk_quiet("noop0.decode", 4'd2);
    step();
    chk_quiet("noop0.exec", 4'd3);
    step();
    chk_fetch("noop1.fetch");

    // PC_up is high exactly one cycle in three on the NOOP loop
    up_count = 0;
    for (int i = 0; i < 9; i++) begin
      if (PC_up) up_count++;
      step();
    end
    chk("noop.pc_up_rate", 16'(up_count), 16'd3);
    chk_fetch("add.fetch");

    // ADD R5 = R1 + R2
    Instr = 16'h3125;
    step();
    chk_quiet("add.decode", 4'd2);
    chk("add.IR_q", IR_q, 16'h3125);
    step();
    chk_out("add.exec", 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 8'h00, 4'h1, 4'h2, 4'h5);
    step();
    chk_fetch("load.fetch");

    // LOAD R4 <- mem[A7]
    Instr = 16'h24A7;
    step();
    chk_quiet("load.decode", 4'd2);
    step();
    chk_out("load.a", 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 8'hA7, 4'h0, 4'h0, 4'h0);
    step();
    chk_out("load.b", 4'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 8'hA7, 4'h0, 4'h0, 4'h4);
    step();
    chk_fetch("store.fetch");

    // STORE mem[33] <- RC
    Instr = 16'h1C33;
    step();
    chk_quiet("store.decode", 4'd2);
    step();
    chk_out("store.exec", 4'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 8'h33, 4'hC, 4'h0, 4'h0);
    step();
    chk_fetch("sub.fetch");

    // SUB R7 = R9 - R8
    Instr = 16'h4987;
    step();
    chk_quiet("sub.decode", 4'd2);
    step();
    chk_out("sub.exec", 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 8'h00, 4'h9, 4'h8, 4'h7);
    step();
    chk_fetch("ill.fetch");

    // Illegal opcode behaves as NOOP
    Instr = 16'hF123;
    step();
    chk_quiet("ill.decode", 4'd2);
    chk("ill.IR_q", IR_q, 16'hF123);
    step();
    chk_quiet("ill.exec", 4'd3);
    step();
    chk_fetch("halt.fetch");

    // HALT parks the FSM
    Instr = 16'h5000;
    step();
    chk_quiet("halt.decode", 4'd2);
    Instr = 16'h3125;
    for (int i = 0; i < 22; i++) begin
      step();
      chk_quiet("halt.hold", 4'd9);
    end

    // Reset out of HALT
    Clr = 1'b0;
    step();
    Clr = 1'b1;
    chk_out("halt.rst", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 4'h0, 4'h0, 4'h0);
    chk("halt.rst.IR_q", IR_q, 16'h0000);
    step();
    chk_fetch("rstld.fetch");

    // Reset in LOAD_A aborts the load; no RF write afterwards
    Instr = 16'h24A7;
    step();
    step();
    chk("rstld.in_load_a", 16'(State), 16'd4);
    Clr = 1'b0;
    step();
    Clr = 1'b1;
    Instr = 16'h0000;
    chk("rstld.state", 16'(State), 16'd0);
    chk("rstld.IR_q", IR_q, 16'h0000);
    chk("rstld.we", 16'(RF_W_en), 16'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rstld.we_after", 16'(RF_W_en), 16'd0);
    end

    // Now in FETCH (INIT, FETCH, DECODE, NOOP, FETCH); reset here beats PC_up
    chk_fetch("rstf.fetch");
    Clr = 1'b0;
    step();
    Clr = 1'b1;
    chk_out("rstf.init", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 4'h0, 4'h0, 4'h0);
    chk("rstf.IR_q", IR_q, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
